// File: rtl/fpga_seq_pkg.sv
// Shared types and constants for the counter-bank ramp sequencer.
package fpga_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_e;

    localparam int unsigned ADR_ID     = 0;
    localparam int unsigned ADR_CTRL   = 1;
    localparam int unsigned ADR_MASK   = 2;
    localparam int unsigned ADR_DWELL  = 3;
    localparam int unsigned ADR_HOLD   = 4;
    localparam int unsigned ADR_STATUS = 5;

    localparam logic [31:0] SEQ_ID_DEFAULT = 32'h5E0C_0001;
    localparam logic [31:0] UNMAPPED_RD    = 32'haa55_6699;
    localparam logic [5:0]  MAX_LEVEL      = 6'd32;

    // A zero step would stall the ramp forever, so it behaves as 1.
    function automatic logic [5:0] step_clamp(input logic [5:0] step);
        if (step == 6'd0)
            return 6'd1;
        if (step > MAX_LEVEL)
            return MAX_LEVEL;
        return step;
    endfunction

    function automatic logic [31:0] therm(input logic [5:0] level);
        logic [32:0] t;
        t = (33'd1 << level) - 33'd1;
        return t[31:0];
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Down-counting step timer: expire_o pulses exactly load_val_i cycles after a load.
module seq_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               expire_o
);
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = (load_val_i == '0) ? DWELL_W'(1) : load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - DWELL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/fpga_cnt_ramp_sequencer.sv
// Wishbone slave that ramps the counter-bank enable vector up, holds, then ramps down.
// Build option: define SEQ_IRQ_EN for the sticky DONE flag and seq_irq_o.
module fpga_cnt_ramp_sequencer
    import fpga_seq_pkg::*;
#(
    parameter int          ADDRWIDTH    = 7,
    parameter int          DATAWIDTH    = 32,
    parameter int          LANES        = 32,
    parameter int          DWELL_W      = 16,
    parameter logic [31:0] SEQ_ID_VALUE = SEQ_ID_DEFAULT
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic                 WBs_STB_i,
    input  logic                 WBs_WE_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    output logic                 WBs_ACK_o,
    output logic [LANES-1:0]     count_enb_o,
    output logic                 seq_irq_o
);
    logic               ack_q, ack_d, wr_en;
    logic               sel_id, sel_ctrl, sel_mask, sel_dwell, sel_hold, sel_status;
    logic               start_w, stop_w;
    logic               loop_q, loop_d;
    logic [5:0]         step_q, step_d, step_eff;
    logic [31:0]        mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, hold_q, hold_d;
    seq_state_e         state_q, state_d;
    logic [5:0]         level_q, level_d, lvl_up, lvl_dn;
    logic [6:0]         lvl_sum;
    logic [15:0]        passes_q, passes_d;
    logic               stop_pend_q, stop_pend_d;
    logic [LANES-1:0]   enb_q, enb_d;
    logic               tmr_load, tmr_expire;
    logic [DWELL_W-1:0] tmr_val;
    logic               done_bit;

    assign sel_id     = (WBs_ADR_i == ADDRWIDTH'(ADR_ID));
    assign sel_ctrl   = (WBs_ADR_i == ADDRWIDTH'(ADR_CTRL));
    assign sel_mask   = (WBs_ADR_i == ADDRWIDTH'(ADR_MASK));
    assign sel_dwell  = (WBs_ADR_i == ADDRWIDTH'(ADR_DWELL));
    assign sel_hold   = (WBs_ADR_i == ADDRWIDTH'(ADR_HOLD));
    assign sel_status = (WBs_ADR_i == ADDRWIDTH'(ADR_STATUS));

    assign ack_d   = WBs_CYC_i & WBs_STB_i & ~ack_q;
    assign wr_en   = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~ack_q;
    assign start_w = wr_en & sel_ctrl & WBs_BYTE_STB_i[0] & WBs_DAT_i[0];
    assign stop_w  = wr_en & sel_ctrl & WBs_BYTE_STB_i[0] & WBs_DAT_i[1];

    // NOTE: every always_comb target gets its hold value first so no path can infer a latch.
    always_comb begin
        loop_d  = loop_q;
        step_d  = step_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        hold_d  = hold_q;
        if (wr_en) begin
            if (sel_ctrl && WBs_BYTE_STB_i[0]) loop_d = WBs_DAT_i[2];
            if (sel_ctrl && WBs_BYTE_STB_i[1]) step_d = WBs_DAT_i[13:8];
            for (int b = 0; b < 4; b++)
                if (sel_mask && WBs_BYTE_STB_i[b]) mask_d[b*8 +: 8] = WBs_DAT_i[b*8 +: 8];
            for (int b = 0; b < DWELL_W/8; b++) begin
                if (sel_dwell && WBs_BYTE_STB_i[b]) dwell_d[b*8 +: 8] = WBs_DAT_i[b*8 +: 8];
                if (sel_hold && WBs_BYTE_STB_i[b])  hold_d[b*8 +: 8]  = WBs_DAT_i[b*8 +: 8];
            end
        end
    end

    assign step_eff = step_clamp(step_q);
    assign lvl_sum  = {1'b0, level_q} + {1'b0, step_eff};
    assign lvl_up   = (lvl_sum >= 7'(MAX_LEVEL)) ? MAX_LEVEL : lvl_sum[5:0];
    assign lvl_dn   = (level_q > step_eff) ? (level_q - step_eff) : 6'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start_w && !stop_w) state_d = ST_RAMP_UP;
            ST_RAMP_UP: begin
                if (stop_w)
                    state_d = ST_RAMP_DOWN;
                else if (tmr_expire && lvl_up == MAX_LEVEL)
                    state_d = ST_HOLD;
            end
            ST_HOLD:      if (stop_w || tmr_expire) state_d = ST_RAMP_DOWN;
            ST_RAMP_DOWN: if (tmr_expire && lvl_dn == 6'd0) state_d = ST_DONE;
            ST_DONE:      state_d = (loop_q && !stop_pend_q && !stop_w) ? ST_RAMP_UP : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // The timer reloads on entry to a timed state and on every expiry that stays put.
    always_comb begin
        level_d = level_q;
        if (state_q == ST_RAMP_UP && tmr_expire && !stop_w)
            level_d = lvl_up;
        else if (state_q == ST_RAMP_DOWN && tmr_expire)
            level_d = lvl_dn;

        tmr_load = (state_d != state_q || tmr_expire) &&
                   (state_d inside {ST_RAMP_UP, ST_HOLD, ST_RAMP_DOWN});
        tmr_val  = (state_d == ST_HOLD) ? hold_q : dwell_q;

        passes_d = passes_q;
        if (state_q == ST_DONE && passes_q != 16'hFFFF)
            passes_d = passes_q + 16'd1;

        stop_pend_d = stop_pend_q;
        if (state_d == ST_IDLE)
            stop_pend_d = 1'b0;
        else if (stop_w)
            stop_pend_d = 1'b1;

        enb_d = mask_q & therm(level_q);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            ack_q       <= 1'b0;
            loop_q      <= 1'b0;
            step_q      <= 6'd1;
            mask_q      <= 32'hFFFF_FFFF;
            dwell_q     <= DWELL_W'(1);
            hold_q      <= DWELL_W'(1);
            state_q     <= ST_IDLE;
            level_q     <= 6'd0;
            passes_q    <= 16'd0;
            stop_pend_q <= 1'b0;
            enb_q       <= '0;
        end else begin
            ack_q       <= ack_d;
            loop_q      <= loop_d;
            step_q      <= step_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            hold_q      <= hold_d;
            state_q     <= state_d;
            level_q     <= level_d;
            passes_q    <= passes_d;
            stop_pend_q <= stop_pend_d;
            enb_q       <= enb_d;
        end
    end

`ifdef SEQ_IRQ_EN
    logic done_q, done_d;

    // Entering DONE outranks a simultaneous software clear.
    always_comb begin
        done_d = done_q;
        if (wr_en && sel_status && WBs_BYTE_STB_i[0] && WBs_DAT_i[7])
            done_d = 1'b0;
        if (state_d == ST_DONE && state_q != ST_DONE)
            done_d = 1'b1;
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i)
            done_q <= 1'b0;
        else
            done_q <= done_d;
    end

    assign done_bit = done_q;
`else
    assign done_bit = 1'b0;
`endif

    always_comb begin
        WBs_DAT_o = DATAWIDTH'(UNMAPPED_RD);
        if (sel_id)
            WBs_DAT_o = DATAWIDTH'(SEQ_ID_VALUE);
        else if (sel_ctrl)
            WBs_DAT_o = DATAWIDTH'({18'b0, step_q, 5'b0, loop_q, 2'b0});
        else if (sel_mask)
            WBs_DAT_o = DATAWIDTH'(mask_q);
        else if (sel_dwell)
            WBs_DAT_o = DATAWIDTH'(dwell_q);
        else if (sel_hold)
            WBs_DAT_o = DATAWIDTH'(hold_q);
        else if (sel_status)
            WBs_DAT_o = DATAWIDTH'({passes_q, 2'b0, level_q, done_bit, 4'b0, state_q});
    end

    seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk        (WBs_CLK_i),
        .rst        (WBs_RST_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    assign WBs_ACK_o   = ack_q;
    assign count_enb_o = enb_q;
    assign seq_irq_o   = done_bit;

endmodule

// File: tb/tb_fpga_cnt_ramp_sequencer.sv
// Directed bench for fpga_cnt_ramp_sequencer; expected values are hand-computed cycle offsets.
module tb_fpga_cnt_ramp_sequencer;

    localparam logic [6:0] A_ID = 7'h0, A_CTRL = 7'h1, A_MASK = 7'h2;
    localparam logic [6:0] A_DWELL = 7'h3, A_HOLD = 7'h4, A_STATUS = 7'h5;

`ifdef SEQ_IRQ_EN
    localparam logic [31:0] DONE_BIT = 32'h0000_0080;
`else
    localparam logic [31:0] DONE_BIT = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  adr = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack;
    logic [31:0] enb;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int rel     = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    fpga_cnt_ramp_sequencer dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .WBs_ADR_i      (adr),
        .WBs_CYC_i      (cyc),
        .WBs_STB_i      (stb),
        .WBs_WE_i       (we),
        .WBs_BYTE_STB_i (be),
        .WBs_DAT_i      (dat_i),
        .WBs_DAT_o      (dat_o),
        .WBs_ACK_o      (ack),
        .count_enb_o    (enb),
        .seq_irq_o      (irq)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic wb_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; be = b;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic wb_read(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        #1 d = dat_o;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance to the negedge following active edge n, counted from the last START/STOP commit.
    task automatic tick_to(input int n);
        while (rel < n) begin
            @(negedge clk);
            rel++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values and single-cycle ack.
        check("rst_enb", enb, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_ID;
        #1;
        check("ack_before", {31'b0, ack}, 32'h0);
        check("rd_id", dat_o, 32'h5E0C_0001);
        @(negedge clk);
        check("ack_pulse", {31'b0, ack}, 32'h1);
        @(negedge clk);
        check("ack_single", {31'b0, ack}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        wb_read(A_MASK, rd);    check("rd_mask_rst", rd, 32'hFFFF_FFFF);
        wb_read(A_STATUS, rd);  check("rd_status_rst", rd, 32'h0);
        wb_read(A_CTRL, rd);    check("rd_ctrl_rst", rd, 32'h0000_0100);
        wb_read(A_DWELL, rd);   check("rd_dwell_rst", rd, 32'h1);
        wb_read(A_HOLD, rd);    check("rd_hold_rst", rd, 32'h1);
        wb_read(7'h7, rd);      check("rd_unmapped", rd, 32'haa55_6699);
        wb_write(A_MASK, 32'h1234_5678, 4'b0101);
        wb_read(A_MASK, rd);    check("mask_bytes", rd, 32'hFF34_FF78);

        // Full pass: STEP=8, DWELL=4, HOLD=10.
        wb_write(A_MASK, 32'hFFFF_FFFF, 4'hF);
        wb_write(A_DWELL, 32'd4, 4'hF);
        wb_write(A_HOLD, 32'd10, 4'hF);
        wb_write(A_CTRL, 32'h0000_0801, 4'hF);
        rel = 0;
        tick_to(4);  check("p_e4", enb, 32'h0);
        tick_to(5);  check("p_e5", enb, 32'h0000_00FF);
        tick_to(8);  check("p_e8", enb, 32'h0000_00FF);
        tick_to(9);  check("p_e9", enb, 32'h0000_FFFF);
        tick_to(13); check("p_e13", enb, 32'h00FF_FFFF);
        tick_to(16); check("p_e16", enb, 32'h00FF_FFFF);
        tick_to(17); check("p_e17", enb, 32'hFFFF_FFFF);
        tick_to(30); check("p_e30", enb, 32'hFFFF_FFFF);
        tick_to(31); check("p_e31", enb, 32'h00FF_FFFF);
        tick_to(35); check("p_e35", enb, 32'h0000_FFFF);
        tick_to(39); check("p_e39", enb, 32'h0000_00FF);
        tick_to(42); check("p_e42", enb, 32'h0000_00FF);
        tick_to(43); check("p_e43", enb, 32'h0);
        wb_read(A_STATUS, rd); check("p_status", rd, 32'h0001_0000 | DONE_BIT);
`ifdef SEQ_IRQ_EN
        check("irq_set", {31'b0, irq}, 32'h1);
        wb_write(A_STATUS, 32'h80, 4'h1);
        check("irq_clr", {31'b0, irq}, 32'h0);
`else
        check("irq_tied", {31'b0, irq}, 32'h0);
`endif

        // START and STOP together in IDLE: stays idle.
        wb_write(A_CTRL, 32'h0000_0803, 4'hF);
        repeat (6) @(negedge clk);
        check("ss_enb", enb, 32'h0);
        wb_read(A_STATUS, rd); check("ss_status", rd, 32'h0001_0000);

        // STEP=0 behaves as 1 with DWELL=1.
        do_reset();
        wb_write(A_CTRL, 32'h0000_0001, 4'hF);
        rel = 0;
        tick_to(2); check("s0_e2", enb, 32'h1);
        tick_to(3); check("s0_e3", enb, 32'h3);
        tick_to(4); check("s0_e4", enb, 32'h7);

        // STEP=40 clamps to 32: full in one step.
        do_reset();
        wb_write(A_CTRL, 32'h0000_2801, 4'hF);
        rel = 0;
        tick_to(1); check("s40_e1", enb, 32'h0);
        tick_to(2); check("s40_e2", enb, 32'hFFFF_FFFF);

        // LOOP with DWELL=HOLD=1, STEP=32: period of 4 cycles.
        do_reset();
        wb_write(A_CTRL, 32'h0000_2805, 4'hF);
        rel = 0;
        tick_to(2); check("lp_e2", enb, 32'hFFFF_FFFF);
        tick_to(4); check("lp_e4", enb, 32'h0);
        tick_to(6); check("lp_e6", enb, 32'hFFFF_FFFF);

        // Masked lanes and a mid-sequence MASK change.
        do_reset();
        wb_write(A_MASK, 32'h0000_F0F0, 4'hF);
        wb_write(A_HOLD, 32'd100, 4'hF);
        wb_write(A_CTRL, 32'h0000_1001, 4'hF);
        rel = 0;
        tick_to(1); check("mk_e1", enb, 32'h0);
        tick_to(2); check("mk_e2", enb, 32'h0000_F0F0);
        tick_to(3); check("mk_e3", enb, 32'h0000_F0F0);
        wb_write(A_MASK, 32'h0F00_0000, 4'hF);
        check("mk_old", enb, 32'h0000_F0F0);
        @(negedge clk);
        check("mk_new", enb, 32'h0F00_0000);

        // LOOP=1, STOP in HOLD, START during ramp-down ignored.
        do_reset();
        wb_write(A_DWELL, 32'd8, 4'hF);
        wb_write(A_HOLD, 32'd50, 4'hF);
        wb_write(A_CTRL, 32'h0000_1005, 4'hF);
        rel = 0;
        tick_to(20);
        wb_read(A_STATUS, rd); check("st_hold", rd, 32'h0000_2002);
        wb_write(A_CTRL, 32'h0000_1006, 4'hF);
        rel = 0;
        wb_write(A_CTRL, 32'h0000_1005, 4'hF);
        rel = 2;
        tick_to(8);  check("st_e8", enb, 32'hFFFF_FFFF);
        tick_to(9);  check("st_e9", enb, 32'h0000_FFFF);
        tick_to(16); check("st_e16", enb, 32'h0000_FFFF);
        tick_to(17); check("st_e17", enb, 32'h0);
        tick_to(40); check("st_noloop", enb, 32'h0);
        wb_read(A_STATUS, rd); check("st_status", rd, 32'h0001_0000 | DONE_BIT);

        // Asynchronous reset mid-ramp clears the enables before the next edge.
        do_reset();
        wb_write(A_CTRL, 32'h0000_0001, 4'hF);
        rel = 0;
        tick_to(3); check("ar_pre", enb, 32'h3);
        rst = 1'b1;
        #1;
        check("ar_enb", enb, 32'h0);
        check("ar_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wb_read(A_STATUS, rd); check("ar_status", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_cnt_ramp_sequencer.md
Name: fpga_cnt_ramp_sequencer

Overview:
Wishbone-slave controller that drives the 32-bit count-enable vector of the parallel counter bank used for power characterisation. Instead of all counters switching on at once under software control, it ramps the number of active counter lanes up in programmable steps, holds at full activity, then ramps back down. This bounds di/dt and gives repeatable power profiles. It sits beside the FPGA register block on the same AHB-to-FPGA Wishbone bridge, and its count_enb_o replaces the software-written enable register.

Parameters:
ADDRWIDTH, 7, Wishbone address width.
DATAWIDTH, 32, Wishbone data width.
LANES, 32, number of counter enable lanes (fixed 32 in this build).
DWELL_W, 16, width of the DWELL and HOLD timers.
SEQ_ID_VALUE, 32'h5E0C_0001, value read at the ID register.

Ports:
WBs_CLK_i  in  1  Wishbone/FPGA clock; single clock domain.
WBs_RST_i  in  1  asynchronous, active-high reset.
WBs_ADR_i  in  ADDRWIDTH  register address.
WBs_CYC_i  in  1  cycle select.
WBs_STB_i  in  1  strobe.
WBs_WE_i  in  1  write enable.
WBs_BYTE_STB_i  in  4  byte enables.
WBs_DAT_i  in  DATAWIDTH  write data.
WBs_DAT_o  out  DATAWIDTH  read data (combinational decode).
WBs_ACK_o  out  1  acknowledge.
count_enb_o  out  LANES  registered enable vector to the counter bank.
seq_irq_o  out  1  pass-complete interrupt; see Optional Feature.

Behaviour:
- Reset state: all outputs 0; registers 0 except MASK=32'hFFFF_FFFF, DWELL=1, HOLD=1, STEP=1; FSM in IDLE, level=0.
- ACK: WBs_ACK_o <= CYC & STB & ~ACK, giving a one-cycle ack on every access. A write commits on the cycle where ACK=0, honouring byte strobes.
- Register map:
  - 0x0 ID (RO) = SEQ_ID_VALUE.
  - 0x1 CTRL: bit0 START (write-1, self-clearing); bit1 STOP (write-1, self-clearing); bit2 LOOP; [13:8] STEP, where 0 is treated as 1 and values above 32 are clamped to 32.
  - 0x2 MASK: lanes eligible for enabling.
  - 0x3 DWELL: cycles per ramp step, [DWELL_W-1:0]; 0 is treated as 1.
  - 0x4 HOLD: cycles at full level; 0 is treated as 1.
  - 0x5 STATUS (RO): [2:0] state; [7] DONE sticky; [13:8] level; [31:16] completed passes, saturating at 16'hFFFF.
  - Unmapped addresses read 32'haa55_6699.
- FSM states: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, DONE=4.
  - IDLE: START → RAMP_UP, timer loaded with DWELL.
  - RAMP_UP: at timer expiry, level = min(level+STEP, 32) and the timer reloads. At level 32 → HOLD with timer=HOLD.
  - HOLD: at expiry → RAMP_DOWN.
  - RAMP_DOWN: at expiry, level = max(level-STEP, 0). At 0 → DONE.
  - DONE: for one cycle, passes++. If LOOP=1 and no stop is pending → RAMP_UP; else → IDLE.
- Timer: counts DWELL (or HOLD) cycles, so level changes exactly DWELL cycles after state entry or the previous change. DWELL/HOLD are sampled at each reload; mid-step writes apply from the next step.
- Enable output: count_enb_o <= MASK & therm(level), where therm(32) = all ones and therm(0) = 0. It lags level by one cycle. MASK writes take effect on the next cycle even mid-sequence.
- START outside IDLE: ignored.
- STOP in RAMP_UP or HOLD: next state is RAMP_DOWN from the current level (graceful). In RAMP_DOWN it only clears the loop intent. In IDLE it has no effect.
- Simultaneous START+STOP in IDLE: STOP wins, so the FSM stays IDLE.
- Reset mid-operation: immediate return to reset state, with count_enb_o = 0 asynchronously.

Optional Feature:
- Macro SEQ_IRQ_EN defined: DONE sticky is set on entry to DONE and cleared by writing 1 to STATUS[7]. seq_irq_o = DONE sticky (level). A set and a clear in the same cycle leave the bit set.
- Macro undefined: seq_irq_o tied 0; STATUS[7] reads 0.

Decomposition:
- Package fpga_seq_pkg:
  - FSM state enum.
  - Register address localparams (0x0..0x5).
  - SEQ_ID_VALUE.
  - Unmapped-read constant.
- Sub-module seq_dwell_timer: load value and load strobe in, expire pulse out, DWELL_W wide, same clock and reset.

Test Plan:
- Reset, then read 0x0, 0x2, 0x5 → 32'h5E0C_0001, 32'hFFFF_FFFF, 0; count_enb_o = 0.
- MASK=all ones, STEP=8, DWELL=4, HOLD=10, LOOP=0, then START → count_enb_o steps 0xFF, 0xFFFF, 0xFFFFFF, 0xFFFFFFFF at 4-cycle spacing. It holds 10 cycles, then 0x00FFFFFF, 0xFFFF, 0xFF, 0. STATUS then shows state=0, passes=1.
- STEP=0 and STEP=40 with DWELL=1 → level increments by 1, respectively reaches 32 in one step (0xFFFFFFFF).
- MASK=32'h0000_F0F0, STEP=16 → count_enb_o = 0x0000F0F0 after the first step, and stays there at full level.
- LOOP=1, then STOP during HOLD → immediate RAMP_DOWN, then IDLE; passes=1; a START issued mid-ramp is ignored.
- With SEQ_IRQ_EN: seq_irq_o rises at DONE and falls after a write of 0x80 to STATUS. Asserting WBs_RST_i mid-RAMP_UP gives count_enb_o = 0 within the same cycle.
